// File: rtl/mem_fifo_ctrl.sv
// FIFO controller for a dual-port memory with a one-cycle registered read.
// It owns the write and read addressing and the upstream and downstream valid/ready handshakes.
// A 2-entry output buffer hides the memory read latency so pops can run back to back.
module mem_fifo_ctrl #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned CW    = $clog2(DEPTH + 3)
) (
  input  logic          clk,
  input  logic          nreset,
  // Upstream push interface
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  // Downstream pop interface
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  // Occupancy: memory + in-flight read + output buffer
  output logic [CW-1:0] count,
  // Memory write port
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_wr_addr,
  output logic [DW-1:0] mem_wr_din,
  // Memory read port (registered, data valid one cycle after rd_en)
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_rd_dout
);

  localparam int unsigned MW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
  localparam logic [MW-1:0] MemFull  = MW'(DEPTH);

  // Memory-side state
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [MW-1:0] mem_cnt_q, mem_cnt_d;
  logic          infl_q, infl_d;

  // Output buffer state: two slots, a head index and an occupancy count
  logic [DW-1:0] ob_data_q [2];
  logic          ob_head_q, ob_head_d;
  logic [1:0]    ob_cnt_q, ob_cnt_d;

  logic          push;
  logic          pop;
  logic          rd_issue;
  logic [1:0]    ob_claim;
  logic          ob_wr_idx;

  // Handshake decode. Ready depends only on registered occupancy, never on out_ready.
  always_comb begin
    in_ready  = nreset & (mem_cnt_q != MemFull);
    push      = in_valid & in_ready;
    out_valid = (ob_cnt_q != 2'd0);
    pop       = out_valid & out_ready;
    out_data  = ob_data_q[ob_head_q];
  end

  // Read issue. An issued read is only allowed when its data is guaranteed a free buffer slot.
  // ob_claim counts the slots that are already spoken for once this cycle's pop is removed.
  always_comb begin
    ob_claim  = ob_cnt_q + {1'b0, infl_q} - {1'b0, pop};
    rd_issue  = (mem_cnt_q != '0) && (ob_claim < 2'd2);
    // Capture always lands in the slot just past the current tail.
    // A capture cannot happen while the buffer is full.
    ob_wr_idx = ob_head_q ^ ob_cnt_q[0];
  end

  // Memory port drive
  always_comb begin
    mem_wr_en   = push;
    mem_wr_addr = wr_ptr_q;
    mem_wr_din  = in_data;
    mem_rd_en   = rd_issue;
    mem_rd_addr = rd_ptr_q;
  end

  // Next-state for pointers, counts and the in-flight flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + AW'(1);
    end
    if (rd_issue) begin
      rd_ptr_d = (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + AW'(1);
    end
    // A word written this cycle only becomes readable next cycle, because mem_cnt_q lags by one.
    mem_cnt_d = mem_cnt_q + MW'(push) - MW'(rd_issue);
    infl_d    = rd_issue;
    ob_cnt_d  = ob_cnt_q + {1'b0, infl_q} - {1'b0, pop};
    ob_head_d = ob_head_q ^ pop;
  end

  // Total occupancy seen by the user
  always_comb begin
    count = CW'(mem_cnt_q) + CW'(infl_q) + CW'(ob_cnt_q);
  end

  // Control state registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
      infl_q    <= 1'b0;
      ob_cnt_q  <= 2'd0;
      ob_head_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_cnt_q <= mem_cnt_d;
      infl_q    <= infl_d;
      ob_cnt_q  <= ob_cnt_d;
      ob_head_q <= ob_head_d;
    end
  end

  // Output buffer storage: capture the memory read data in the cycle after issue
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ob_data_q[0] <= '0;
      ob_data_q[1] <= '0;
    end else if (infl_q) begin
      ob_data_q[ob_wr_idx] <= mem_rd_dout;
    end
  end

  // Structural invariants of the issue rule
  ob_no_overflow_a: assert property (@(posedge clk) disable iff (!nreset)
    ob_cnt_q <= 2'd2);
  capture_has_slot_a: assert property (@(posedge clk) disable iff (!nreset)
    !(infl_q && (ob_cnt_q == 2'd2)));
  mem_cnt_bound_a: assert property (@(posedge clk) disable iff (!nreset)
    mem_cnt_q <= MemFull);

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Bench for mem_fifo_ctrl: a DEPTH=32 instance runs the directed sequences.
// A DEPTH=5 instance is exercised with random handshakes.
// Negedge monitors score pops against queues that are filled from accepted pushes.
module tb_mem_fifo_ctrl;

  localparam int unsigned DW     = 32;
  localparam int unsigned ADEPTH = 32;
  localparam int unsigned AAW    = 5;
  localparam int unsigned ACW    = 6;
  localparam int unsigned BDEPTH = 5;
  localparam int unsigned BAW    = 3;
  localparam int unsigned BCW    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A (DEPTH=32)
  logic           a_nreset, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [DW-1:0]  a_in_data, a_out_data, a_mem_wr_din, a_mem_rd_dout;
  logic [ACW-1:0] a_count;
  logic           a_mem_wr_en, a_mem_rd_en;
  logic [AAW-1:0] a_mem_wr_addr, a_mem_rd_addr;
  logic [DW-1:0]  a_mem [ADEPTH];

  // Instance B (DEPTH=5)
  logic           b_nreset, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [DW-1:0]  b_in_data, b_out_data, b_mem_wr_din, b_mem_rd_dout;
  logic [BCW-1:0] b_count;
  logic           b_mem_wr_en, b_mem_rd_en;
  logic [BAW-1:0] b_mem_wr_addr, b_mem_rd_addr;
  logic [DW-1:0]  b_mem [BDEPTH];

  mem_fifo_ctrl #(.DW(DW), .DEPTH(ADEPTH)) dut_a (
    .clk(clk), .nreset(a_nreset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count),
    .mem_wr_en(a_mem_wr_en), .mem_wr_addr(a_mem_wr_addr), .mem_wr_din(a_mem_wr_din),
    .mem_rd_en(a_mem_rd_en), .mem_rd_addr(a_mem_rd_addr), .mem_rd_dout(a_mem_rd_dout)
  );

  mem_fifo_ctrl #(.DW(DW), .DEPTH(BDEPTH)) dut_b (
    .clk(clk), .nreset(b_nreset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count),
    .mem_wr_en(b_mem_wr_en), .mem_wr_addr(b_mem_wr_addr), .mem_wr_din(b_mem_wr_din),
    .mem_rd_en(b_mem_rd_en), .mem_rd_addr(b_mem_rd_addr), .mem_rd_dout(b_mem_rd_dout)
  );

  // Behavioural dual-port memories with a one-cycle registered read
  always @(posedge clk) begin
    if (a_mem_wr_en) a_mem[a_mem_wr_addr] <= a_mem_wr_din;
    if (a_mem_rd_en) a_mem_rd_dout <= a_mem[a_mem_rd_addr];
    if (b_mem_wr_en) b_mem[b_mem_wr_addr] <= b_mem_wr_din;
    if (b_mem_rd_en) b_mem_rd_dout <= b_mem[b_mem_rd_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboards and address models
  logic [DW-1:0] a_q[$];
  logic [DW-1:0] b_q[$];
  logic [DW-1:0] a_exp, b_exp;
  int a_wa = 0, a_ra = 0, b_wa = 0, b_ra = 0, b_mc = 0;
  int a_max = 0, b_max = 0;

  always @(negedge clk) begin
    if (!a_nreset) begin
      a_q.delete();
      a_wa = 0;
      a_ra = 0;
    end else begin
      if (a_out_valid && a_out_ready) begin
        if (a_q.size() == 0) chk("a_pop_with_empty_scoreboard", a_q.size(), 1);
        else begin
          a_exp = a_q.pop_front();
          chk("a_pop_data", a_out_data, a_exp);
        end
      end
      chk("a_wr_en", a_mem_wr_en, a_in_valid & a_in_ready);
      if (a_in_valid && a_in_ready) begin
        chk("a_wr_addr", a_mem_wr_addr, a_wa);
        chk("a_wr_din", a_mem_wr_din, a_in_data);
        a_q.push_back(a_in_data);
        a_wa = (a_wa == ADEPTH - 1) ? 0 : a_wa + 1;
      end
      if (a_mem_rd_en) begin
        chk("a_rd_addr", a_mem_rd_addr, a_ra);
        a_ra = (a_ra == ADEPTH - 1) ? 0 : a_ra + 1;
      end
      if (int'(a_count) > a_max) a_max = int'(a_count);
    end
  end

  always @(negedge clk) begin
    if (!b_nreset) begin
      b_q.delete();
      b_wa = 0;
      b_ra = 0;
      b_mc = 0;
    end else begin
      if (b_out_valid && b_out_ready) begin
        if (b_q.size() == 0) chk("b_pop_with_empty_scoreboard", b_q.size(), 1);
        else begin
          b_exp = b_q.pop_front();
          chk("b_pop_data", b_out_data, b_exp);
        end
      end
      chk("b_in_ready_vs_memcnt", b_in_ready, b_mc != BDEPTH);
      if (b_in_valid && b_in_ready) begin
        chk("b_wr_addr", b_mem_wr_addr, b_wa);
        b_q.push_back(b_in_data);
        b_wa = (b_wa == BDEPTH - 1) ? 0 : b_wa + 1;
        b_mc++;
      end
      if (b_mem_rd_en) begin
        chk("b_rd_nonempty", b_mc != 0, 1);
        chk("b_rd_addr", b_mem_rd_addr, b_ra);
        b_ra = (b_ra == BDEPTH - 1) ? 0 : b_ra + 1;
        b_mc--;
      end
      if (int'(b_count) > b_max) b_max = int'(b_count);
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until instance A is empty and its scoreboard drained
  task automatic wait_a_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (a_count == '0 && a_q.size() == 0) break;
    end
    chk({name, "_count"}, a_count, 0);
    chk({name, "_sb_left"}, a_q.size(), 0);
  endtask

  // Push into A with out_ready low until it refuses; returns accepted words
  task automatic fill_a(input logic [DW-1:0] base, output int acc);
    acc = 0;
    for (int k = 0; k < 50; k++) begin
      drive_edge();
      a_in_valid = 1'b1;
      a_in_data  = base + DW'(k);
      @(negedge clk);
      if (!a_in_ready) break;
      acc++;
    end
  endtask

  int acc;
  int waited;

  initial begin
    a_nreset = 1'b0; b_nreset = 1'b0;
    a_in_valid = 1'b1; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

    // Reset: ready held low even with a pending push
    repeat (3) @(negedge clk);
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_count", a_count, 0);
    chk("rst_mem_wr_en", a_mem_wr_en, 0);
    chk("rst_mem_rd_en", a_mem_rd_en, 0);
    a_in_valid = 1'b0;
    #2;
    a_nreset = 1'b1; b_nreset = 1'b1;

    // Single push, three-cycle latency
    drive_edge();
    a_in_valid = 1'b1; a_in_data = 32'hDEADBEEF; a_out_ready = 1'b1;
    @(negedge clk);
    chk("t1_in_ready", a_in_ready, 1);
    chk("t1_wr_addr0", a_mem_wr_addr, 0);
    drive_edge();
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("t1_count_t1", a_count, 1);
    chk("t1_rd_en_t1", a_mem_rd_en, 1);
    chk("t1_out_valid_t1", a_out_valid, 0);
    @(negedge clk);
    chk("t1_count_t2", a_count, 1);
    chk("t1_out_valid_t2", a_out_valid, 0);
    @(negedge clk);
    chk("t1_out_valid_t3", a_out_valid, 1);
    chk("t1_out_data_t3", a_out_data, 32'hDEADBEEF);
    chk("t1_count_t3", a_count, 1);
    @(negedge clk);
    chk("t1_count_after_pop", a_count, 0);
    chk("t1_out_valid_after_pop", a_out_valid, 0);

    // 100 back-to-back pushes, no bubbles on the pop side
    for (int i = 0; i < 103; i++) begin
      drive_edge();
      a_in_valid = (i < 100);
      a_in_data  = DW'(i);
      @(negedge clk);
      if (i < 100) chk("t2_in_ready", a_in_ready, 1);
      if (i >= 3) chk("t2_out_valid_stream", a_out_valid, 1);
    end
    drive_edge();
    a_in_valid = 1'b0;
    wait_a_idle("t2_idle", 10);

    // Fill with out_ready low: 32 in memory + 2 in the buffer
    a_out_ready = 1'b0;
    fill_a(32'd1000, acc);
    chk("t3_accepted", acc, 34);
    chk("t3_count_full", a_count, 34);
    chk("t3_rd_en_full", a_mem_rd_en, 0);
    chk("t3_in_ready_full", a_in_ready, 0);
    drive_edge();
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    @(negedge clk);
    chk("t3_in_ready_pop_cycle", a_in_ready, 0);
    chk("t3_rd_en_pop_cycle", a_mem_rd_en, 1);
    @(negedge clk);
    chk("t3_in_ready_after", a_in_ready, 1);
    wait_a_idle("t3_idle", 60);

    // Full, then push and pop held every cycle
    a_out_ready = 1'b0;
    fill_a(32'd1500, acc);
    chk("t6_accepted", acc, 34);
    for (int j = 0; j < 60; j++) begin
      drive_edge();
      a_in_valid = 1'b1; a_in_data = 32'd2000 + DW'(j); a_out_ready = 1'b1;
      @(negedge clk);
      chk("t6_in_ready_seq", a_in_ready, j != 0);
      if (j == 10) chk("t6_count_steady", a_count, 33);
    end
    drive_edge();
    a_in_valid = 1'b0;
    wait_a_idle("t6_idle", 80);

    // Reset mid-operation with count=10 and a read in flight
    a_out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive_edge();
      a_in_valid = 1'b1; a_in_data = 32'd3000 + DW'(k);
    end
    drive_edge();
    a_in_valid = 1'b0;
    repeat (4) drive_edge();
    a_in_valid = 1'b1; a_in_data = 32'd3010; a_out_ready = 1'b1;
    drive_edge();
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    @(negedge clk);
    chk("t5_count_before_rst", a_count, 10);
    #2;
    a_nreset = 1'b0;
    #1;
    chk("t5_rst_count", a_count, 0);
    chk("t5_rst_out_valid", a_out_valid, 0);
    chk("t5_rst_rd_en", a_mem_rd_en, 0);
    chk("t5_rst_in_ready", a_in_ready, 0);
    @(negedge clk);
    #2;
    a_nreset = 1'b1;
    drive_edge();
    a_in_valid = 1'b1; a_in_data = 32'h5; a_out_ready = 1'b1;
    drive_edge();
    a_in_valid = 1'b0;
    waited = 0;
    while (!a_out_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("t5_post_rst_valid", a_out_valid, 1);
    chk("t5_post_rst_data", a_out_data, 32'h5);
    wait_a_idle("t5_idle", 10);

    // DEPTH=5: random 50% valid/ready for 2000 cycles
    for (int c = 0; c < 2000; c++) begin
      drive_edge();
      b_in_valid  = 1'($urandom_range(0, 1));
      b_in_data   = $urandom;
      b_out_ready = 1'($urandom_range(0, 1));
    end
    drive_edge();
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b_count == '0 && b_q.size() == 0) break;
    end
    chk("b_drain_count", b_count, 0);
    chk("b_drain_sb_left", b_q.size(), 0);

    chk("a_max_count_le_34", a_max <= 34, 1);
    chk("b_max_count_le_7", b_max <= 7, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
